// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with valid/ready handshake.
// A two-entry skid buffer (main + skid) sustains one transfer per cycle while
// in_ready is taken from state registers only, so it has no combinational
// path from out_ready. Flush drops every held entry and zeroes the ctrl
// fields so that a squashed instruction causes no side effects; the payload
// registers keep their old contents.
// Optional feature: define PIPE_PERF_EN to add the saturating stall_cnt and
// bubble_cnt performance counters.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    // Each state's encoding equals the number of entries held
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Outputs come straight from the state registers
    assign in_ready   = (r_state != S_TWO);
    assign out_valid  = (r_state != S_EMPTY);
    assign out_ctrl   = out_valid ? r_main_ctrl : '0;
    assign out_data   = r_main_data;
    assign occupancy  = r_state;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and entry-load decisions; flush overrides every handshake
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_next   = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_next = S_EMPTY;
                    end else if (w_in_xfer) begin
                        w_state_next = S_TWO;
                        w_load_skid  = 1'b1;
                    end
                end
                S_TWO: begin
                    if (w_out_xfer) begin
                        w_state_next     = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_EMPTY;
                end
            endcase
        end
    end

    // Entry storage: flush zeroes ctrl only, payload keeps its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

    // Saturating stall/bubble counters; only reset clears them, flush does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (!out_valid && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vectors with hand-computed expectations for
// pipe_stage_skid (reset, streaming, backpressure, flush, reset mid-TWO and,
// with PIPE_PERF_EN, counter saturation).
module tb_pipe_stage_skid;
    localparam int CW = 8;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_PERF_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int n0;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Count the comparison and report any miscompare on one line
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, counting a downstream transfer presented before it
    task automatic tick();
        if (rst_n && out_valid && out_ready) n_out++;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ctrl",  out_ctrl,  8'h00);
        chk("rst_out_data",  out_data,  128'h0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_occ",       occupancy, 2'd0);
`ifdef PIPE_PERF_EN
        chk("rst_stall_cnt",  stall_cnt,  16'h0);
        chk("rst_bubble_cnt", bubble_cnt, 16'h0);
`endif
        rst_n = 1'b1;
        tick();
        chk("idle_out_valid", out_valid, 1'b0);

        // Stream 1..100 with both sides always willing
        out_ready = 1'b1;
        n0 = n_out;
        for (int k = 1; k <= 100; k++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(k);
            in_data  = DW'(k);
            tick();
            chk($sformatf("stream_valid_%0d", k), out_valid, 1'b1);
            chk($sformatf("stream_data_%0d", k),  out_data,  DW'(k));
            chk($sformatf("stream_ctrl_%0d", k),  out_ctrl,  CW'(k));
            chk($sformatf("stream_rdy_%0d", k),   in_ready,  1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_count", n_out - n0, 100);
        chk("stream_drain_valid", out_valid, 1'b0);
        chk("stream_drain_ctrl",  out_ctrl,  8'h00);
        chk("stream_drain_occ",   occupancy, 2'd0);

        // Backpressure: A and B fill the stage, C waits upstream
        out_ready = 1'b0;
        push(8'h11, 128'hA);
        chk("bp_occ1", occupancy, 2'd1);
        push(8'h22, 128'hB);
        chk("bp_occ2",   occupancy, 2'd2);
        chk("bp_rdy0",   in_ready,  1'b0);
        in_valid = 1'b1; in_ctrl = 8'h77; in_data = 128'hBAD;
        tick();
        chk("bp_ignore_occ",  occupancy, 2'd2);
        chk("bp_ignore_head", out_data,  128'hA);
        in_ctrl = 8'h33; in_data = 128'hC;
        tick();
        chk("bp_hold_head", out_data, 128'hA);
        chk("bp_A_ctrl",    out_ctrl, 8'h11);
        out_ready = 1'b1;
        n0 = n_out;
        tick();
        chk("bp_B_data", out_data,  128'hB);
        chk("bp_B_ctrl", out_ctrl,  8'h22);
        chk("bp_B_occ",  occupancy, 2'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_C_data", out_data,  128'hC);
        chk("bp_C_ctrl", out_ctrl,  8'h33);
        chk("bp_C_occ",  occupancy, 2'd1);
        tick();
        chk("bp_empty_valid", out_valid,   1'b0);
        chk("bp_count",       n_out - n0,  3);

        // Flush in TWO with a same-cycle input
        out_ready = 1'b0;
        push(8'hFF, 128'h101);
        push(8'hFF, 128'h102);
        chk("fl_occ2", occupancy, 2'd2);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 128'hDEAD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ctrl",  out_ctrl,  8'h00);
        chk("fl_occ",   occupancy, 2'd0);
        chk("fl_rdy",   in_ready,  1'b1);
        out_ready = 1'b1;
        n0 = n_out;
        tick();
        tick();
        chk("fl_no_ghost_valid", out_valid,  1'b0);
        chk("fl_no_ghost_count", n_out - n0, 0);
        push(8'h5A, 128'h200);
        chk("fl_next_data",  out_data,  128'h200);
        chk("fl_next_ctrl",  out_ctrl,  8'h5A);
        chk("fl_next_occ",   occupancy, 2'd1);

        // Flush in ONE together with a downstream transfer
        n0 = n_out;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flx_valid", out_valid,  1'b0);
        chk("flx_ctrl",  out_ctrl,   8'h00);
        chk("flx_occ",   occupancy,  2'd0);
        chk("flx_count", n_out - n0, 1);
        tick();
        chk("flx_after_valid", out_valid,  1'b0);
        chk("flx_after_count", n_out - n0, 1);

        // Asynchronous reset while holding two entries
        out_ready = 1'b0;
        push(8'hC1, 128'h301);
        push(8'hC2, 128'h302);
        chk("ar_pre_occ",   occupancy, 2'd2);
        chk("ar_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_ctrl",  out_ctrl,  8'h00);
        chk("ar_occ",   occupancy, 2'd0);
        chk("ar_rdy",   in_ready,  1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef PIPE_PERF_EN
        // Stall a valid head long enough to saturate stall_cnt
        push(8'h01, 128'h400);
        tick();
        chk("perf_stall_1",  stall_cnt,  16'd1);
        chk("perf_bubble_1", bubble_cnt, 16'd1);
        for (int i = 0; i < 70000; i++) tick();
        chk("perf_stall_sat", stall_cnt,  16'hFFFF);
        chk("perf_bubble",    bubble_cnt, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
